mmu_banked: RTL and testbench
=============================

# mmu_banked

Programmable chip-select decoder with per-device wait-state generation for the 6502 bus. Decodes the top `DECODE_BITS` address bits through a writable page map into one-hot active-low chip selects. It stretches accesses to slow devices by holding `rdy` low for a programmed number of clocks. It sits between the CPU address bus and the EEPROM/RAM/VIA/ACIA selects, and its map registers are written by the CPU through a small configuration port.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: CPU address width.
- `DECODE_BITS`, 3: upper address bits decoded; PAGES = 2^DECODE_BITS; legal range 1..4.
- `NUM_CS`, 4: number of chip-select outputs; legal range 1..16.
- `WAIT_WIDTH`, 3: width of each wait-state count.

Ports:
- `clock`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `address`  in  ADDR_WIDTH  CPU address.
- `valid`  in  1  CPU access in progress this cycle.
- `cfg_we`  in  1  configuration write strobe, sampled on the rising edge.
- `cfg_addr`  in  5  configuration register select.
- `cfg_wdata`  in  8  configuration write data.
- `cs_n`  out  NUM_CS  active-low chip selects, at most one low at a time.
- `rdy`  out  1  high = the current access completes this cycle.
- `decode_miss`  out  1  high when `address` falls on a disabled page.

## Operation
- Page = `address[ADDR_WIDTH-1 -: DECODE_BITS]`. Each page-map entry holds {enable, cs index[3:0]}.
- `cs_n[i]` is low only when the entry for the page has enable=1 and index=i. All other outputs are high.
- An entry whose index is ≥ NUM_CS drives every `cs_n` high and sets `decode_miss`=1.
- Decode is combinational from `address` and the map registers, independent of `valid`.
- While `reset_n`=0, all `cs_n`=1, `rdy`=1 and `decode_miss`=0, combinationally.
- Config writes:
  - `cfg_addr[4]`=0: write map entry `cfg_addr[3:0]` (ignored if ≥ PAGES). enable=`cfg_wdata[7]`, index=`cfg_wdata[3:0]`.
  - `cfg_addr[4]`=1: write wait register `cfg_addr[3:0]` (ignored if ≥ NUM_CS) with `cfg_wdata[WAIT_WIDTH-1:0]`.
- Reset map for the default parameters:
  - pages 0–3: enable, cs0 (RAM)
  - pages 4–5: cs2 (VIA)
  - page 6: cs3 (ACIA)
  - page 7: cs1 (EEPROM)
- Reset map for other parameters: page p maps to cs (p mod NUM_CS), enabled. All wait registers reset to 0.
- Wait FSM states are IDLE, WAIT and DONE.
  - IDLE: `rdy` = 1 unless `valid`=1, the page is enabled and W = wait[selected cs] > 0. In that case `rdy`=0, cnt←W−1, next state is WAIT if W>1, else DONE.
  - WAIT: `rdy`=0; cnt decrements; when cnt reaches 1, go to DONE.
  - DONE: `rdy`=1; go to IDLE on the next edge.
  - `valid`=0 in WAIT or DONE aborts the access: go to IDLE with `rdy`=1 combinationally.
- An access to a disabled page never waits.
- The wait count is latched at access start. Later writes to the wait register affect only later accesses. Map writes take effect on decode the cycle after the write edge.

## Timing
- Chip selects have 0-cycle latency from `address`. `rdy` is combinational in IDLE and registered-state-driven elsewhere.
- An access with W wait states holds `rdy` low for exactly W cycles; `rdy` is high in cycle W+1.
- Back-to-back accesses: after DONE, one IDLE cycle elapses. A `valid` high in that cycle starts the next access immediately.
- Asserting `reset_n` low mid-wait returns the FSM to IDLE asynchronously and restores the reset map and wait values.
- A simultaneous `cfg_we` and access start: the access uses the old wait value. The new map entry takes effect next cycle.

## Configuration
- `MMU_WAIT_STATES_EN` defined: the wait registers and the wait FSM are present, as described above.
- `MMU_WAIT_STATES_EN` not defined: there are no wait registers or FSM. `rdy` is tied to 1, and writes with `cfg_addr[4]`=1 are ignored. Decode behaviour is identical in both builds.

## Test plan
- Reset defaults:
  - address 0x0000 → `cs_n`=1110
  - 0x8000 → 1011
  - 0xC000 → 0111
  - 0xE000 → 1101
  - `rdy`=1
- Remap: write cfg_addr 0x07 with 0x80 (page 7 to cs0), then address 0xF000 → `cs_n`=1110 the next cycle. Write cfg_addr 0x07 with 0x00 → `cs_n`=1111, `decode_miss`=1.
- Wait states: write cfg_addr 0x11 with 3, hold `valid` at 0xE000 → `rdy`=0,0,0,1, then 1 in IDLE. With W=1 → `rdy`=0,1.
- Abort: W=3, drop `valid` after 1 wait cycle → `rdy`=1 the same cycle. The next access to 0xE000 again waits 3 cycles.
- Reset mid-wait: W=5, pull `reset_n` low in the 2nd wait cycle → all `cs_n` and `rdy` high immediately. After release, 0xE000 has 0 waits.
- Out-of-range index: NUM_CS=4, write entry 0 with 0x85 → address 0x0000 gives `cs_n`=1111, `decode_miss`=1, `rdy`=1 with `valid`.

Source files
------------

// File: rtl/mmu_banked_if.sv
// CPU-side bus and configuration port of the banked chip-select decoder.
// The CPU drives the master side; mmu_banked attaches to the slave side.
interface mmu_banked_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_CS     = 4
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  valid;
  logic                  cfg_we;
  logic [4:0]            cfg_addr;
  logic [7:0]            cfg_wdata;
  logic [NUM_CS-1:0]     cs_n;
  logic                  rdy;
  logic                  decode_miss;

  modport master (
    output address, valid, cfg_we, cfg_addr, cfg_wdata,
    input  cs_n, rdy, decode_miss
  );

  modport slave (
    input  address, valid, cfg_we, cfg_addr, cfg_wdata,
    output cs_n, rdy, decode_miss
  );
endinterface

// File: rtl/mmu_banked.sv
// Programmable page-map chip-select decoder for the 6502 bus with optional
// per-device wait states (present only when MMU_WAIT_STATES_EN is defined).
module mmu_banked #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DECODE_BITS = 3,
  parameter int unsigned NUM_CS      = 4,
  parameter int unsigned WAIT_WIDTH  = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  mmu_banked_if.slave  bus
);
  localparam int unsigned PAGES = 1 << DECODE_BITS;

  logic                   map_en  [PAGES];
  logic [3:0]             map_idx [PAGES];
  logic [DECODE_BITS-1:0] page;
  logic                   page_en;
  logic [3:0]             page_idx;
  logic [NUM_CS-1:0]      match;
  logic                   hit;
  logic                   unused_ok;

  // Board memory map for the stock build; any other geometry spreads pages
  // round-robin over the available selects.
  function automatic logic [3:0] reset_idx(input int unsigned p);
    if (DECODE_BITS == 3 && NUM_CS == 4) begin
      case (p)
        0, 1, 2, 3: return 4'd0;
        4, 5:       return 4'd2;
        6:          return 4'd3;
        default:    return 4'd1;
      endcase
    end
    return 4'(p % NUM_CS);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < PAGES; p++) begin
        map_en[p]  <= 1'b1;
        map_idx[p] <= reset_idx(p);
      end
    end else if (bus.cfg_we && !bus.cfg_addr[4]) begin
      for (int unsigned p = 0; p < PAGES; p++) begin
        if (bus.cfg_addr[3:0] == 4'(p)) begin
          map_en[p]  <= bus.cfg_wdata[7];
          map_idx[p] <= bus.cfg_wdata[3:0];
        end
      end
    end
  end

  assign page = bus.address[ADDR_WIDTH-1 -: DECODE_BITS];

  always_comb begin
    page_en  = 1'b0;
    page_idx = '0;
    for (int unsigned p = 0; p < PAGES; p++) begin
      if (page == DECODE_BITS'(p)) begin
        page_en  = map_en[p];
        page_idx = map_idx[p];
      end
    end
    match = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      match[i] = (page_idx == 4'(i));
    end
  end

  // An index with no matching select counts as a miss, same as a disabled page.
  assign hit             = page_en && (|match);
  assign bus.cs_n        = (reset_n && hit) ? ~match : '1;
  assign bus.decode_miss = reset_n && !hit;

  assign unused_ok = ^{bus.address, bus.cfg_wdata, bus.cfg_addr, bus.valid, bus.cfg_we};

`ifdef MMU_WAIT_STATES_EN
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [WAIT_WIDTH-1:0] wait_tbl [NUM_CS];
  logic [WAIT_WIDTH-1:0] sel_wait;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rdy_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        wait_tbl[i] <= '0;
      end
    end else if (bus.cfg_we && bus.cfg_addr[4]) begin
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        if (bus.cfg_addr[3:0] == 4'(i)) begin
          wait_tbl[i] <= bus.cfg_wdata[WAIT_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    sel_wait = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (match[i]) begin
        sel_wait = wait_tbl[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first low-rdy cycle is spent in IDLE, so WAIT only covers W-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.valid && hit && sel_wait != '0) begin
          rdy_d   = 1'b0;
          cnt_d   = sel_wait - WAIT_WIDTH'(1);
          state_d = (sel_wait > WAIT_WIDTH'(1)) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (!bus.valid) begin
          state_d = IDLE;
        end else begin
          rdy_d = 1'b0;
          if (cnt_q == WAIT_WIDTH'(1)) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - WAIT_WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rdy = reset_n ? rdy_d : 1'b1;
`else
  logic [WAIT_WIDTH-1:0] unused_wait_bits;

  assign unused_wait_bits = bus.cfg_wdata[WAIT_WIDTH-1:0];
  assign bus.rdy          = 1'b1;
`endif

endmodule

// File: tb/tb_mmu_banked.sv
// Self-checking bench for mmu_banked: directed vector table, hand-written
// wait/abort/reset sequences, and randomized traffic against a cycle model.
module tb_mmu_banked;
  localparam bit WS =
`ifdef MMU_WAIT_STATES_EN
    1'b1;
`else
    1'b0;
`endif

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  mmu_banked_if #(.ADDR_WIDTH(16), .NUM_CS(4)) bus ();

  mmu_banked #(
    .ADDR_WIDTH(16), .DECODE_BITS(3), .NUM_CS(4), .WAIT_WIDTH(3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: page map, wait table, and remaining low-rdy cycles.
  logic       m_en   [8];
  logic [3:0] m_idx  [8];
  int         m_wait [4];
  int         m_low;
  bit         m_done;

  typedef struct {
    logic [15:0] addr;
    logic        v;
    logic        we;
    logic [4:0]  ca;
    logic [7:0]  wd;
    logic [3:0]  cs;
    logic        miss;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 8; p++) m_en[p] = 1'b1;
    m_idx[0] = 0; m_idx[1] = 0; m_idx[2] = 0; m_idx[3] = 0;
    m_idx[4] = 2; m_idx[5] = 2; m_idx[6] = 3; m_idx[7] = 1;
    for (int i = 0; i < 4; i++) m_wait[i] = 0;
    m_low  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_cfg(input logic [4:0] ca, input logic [7:0] wd);
    int n;
    n = int'(ca[3:0]);
    if (!ca[4] && n < 8) begin
      m_en[n]  = wd[7];
      m_idx[n] = wd[3:0];
    end else if (ca[4] && WS && n < 4) begin
      m_wait[n] = int'(wd[2:0]);
    end
  endtask

  // Drive one cycle (called just after a rising edge), check at the falling edge.
  task automatic step(input logic [15:0] a, input logic v, input logic we,
                      input logic [4:0] ca, input logic [7:0] wd,
                      output logic [3:0] g_cs, output logic g_miss, output logic g_rdy);
    int         pg;
    int         w;
    bit         hit;
    logic [3:0] e_cs;
    logic       e_rdy;
    bus.address = a; bus.valid = v; bus.cfg_we = we; bus.cfg_addr = ca; bus.cfg_wdata = wd;
    @(negedge clock);
    pg   = int'(a[15:13]);
    hit  = m_en[pg] && (m_idx[pg] < 4);
    e_cs = hit ? ~(4'b0001 << m_idx[pg]) : 4'hF;
    w    = hit ? m_wait[m_idx[pg]] : 0;
    if (m_low > 0) begin
      if (!v) begin
        e_rdy = 1'b1; m_low = 0;
      end else begin
        e_rdy = 1'b0; m_low--;
        if (m_low == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      e_rdy = 1'b1; m_done = 1'b0;
    end else if (v && hit && w > 0) begin
      e_rdy = 1'b0; m_low = w - 1; m_done = (m_low == 0);
    end else begin
      e_rdy = 1'b1;
    end
    g_cs = bus.cs_n; g_miss = bus.decode_miss; g_rdy = bus.rdy;
    check($sformatf("model_cs a=%h", a), g_cs, e_cs);
    check($sformatf("model_miss a=%h", a), g_miss, !hit);
    check($sformatf("model_rdy a=%h", a), g_rdy, e_rdy);
    @(posedge clock);
    if (we) model_cfg(ca, wd);
    #1;
  endtask

  task automatic seq(input logic [15:0] a, input logic v, input logic we,
                     input logic [4:0] ca, input logic [7:0] wd,
                     input logic exp_rdy, input string name);
    logic [3:0] c; logic m; logic r;
    step(a, v, we, ca, wd, c, m, r);
    check(name, r, exp_rdy);
  endtask

  initial begin
    logic [3:0]  c;
    logic        m, r;
    logic [15:0] cur;
    logic [4:0]  ca;
    logic [7:0]  wd;
    logic        we, v;
    checks = 0; failures = 0;

    reset_n = 1'b0;
    bus.address = 16'h0000; bus.valid = 1'b1; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0; bus.cfg_wdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_cs", bus.cs_n, 4'hF);
    check("rst_rdy", bus.rdy, 1'b1);
    check("rst_miss", bus.decode_miss, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    tbl.push_back('{16'h0000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1110, 1'b0, 1'b1});
    tbl.push_back('{16'h8000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1011, 1'b0, 1'b1});
    tbl.push_back('{16'hC000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b0111, 1'b0, 1'b1});
    tbl.push_back('{16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1101, 1'b0, 1'b1});
    tbl.push_back('{16'h2000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1110, 1'b0, 1'b1});
    tbl.push_back('{16'hA000, 1'b0, 1'b0, 5'h00, 8'h00, 4'b1011, 1'b0, 1'b1});
    tbl.push_back('{16'hE000, 1'b0, 1'b1, 5'h07, 8'h80, 4'b1101, 1'b0, 1'b1});
    tbl.push_back('{16'hF000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1110, 1'b0, 1'b1});
    tbl.push_back('{16'hF000, 1'b0, 1'b1, 5'h07, 8'h00, 4'b1110, 1'b0, 1'b1});
    tbl.push_back('{16'hF000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1111, 1'b1, 1'b1});
    tbl.push_back('{16'h0000, 1'b0, 1'b1, 5'h07, 8'h81, 4'b1110, 1'b0, 1'b1});
    tbl.push_back('{16'hE000, 1'b0, 1'b1, 5'h08, 8'h83, 4'b1101, 1'b0, 1'b1});
    tbl.push_back('{16'h0000, 1'b0, 1'b0, 5'h00, 8'h00, 4'b1110, 1'b0, 1'b1});
    tbl.push_back('{16'h0000, 1'b0, 1'b1, 5'h00, 8'h85, 4'b1110, 1'b0, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1111, 1'b1, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 1'b1, 5'h00, 8'h80, 4'b1111, 1'b1, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 1'b0, 5'h00, 8'h00, 4'b1110, 1'b0, 1'b1});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].addr, tbl[i].v, tbl[i].we, tbl[i].ca, tbl[i].wd, c, m, r);
      check($sformatf("tbl%0d_cs", i), c, tbl[i].cs);
      check($sformatf("tbl%0d_miss", i), m, tbl[i].miss);
      check($sformatf("tbl%0d_rdy", i), r, tbl[i].rdy);
    end

    // W=3 on cs1, full access.
    seq(16'h0000, 1'b0, 1'b1, 5'h11, 8'h03, 1'b1, "w3_cfg");
    for (int i = 0; i < 3; i++) seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "w3_low");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "w3_done");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "w3_idle");
    // W=1.
    seq(16'h0000, 1'b0, 1'b1, 5'h11, 8'h01, 1'b1, "w1_cfg");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "w1_low");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "w1_done");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "w1_idle");
    // Wait write on the access start edge: this access keeps W=1, next gets W=3.
    seq(16'hE000, 1'b1, 1'b1, 5'h11, 8'h03, !WS, "simul_low");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "simul_done");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "simul_idle");
    for (int i = 0; i < 3; i++) seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "simul_new_low");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "simul_new_done");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "simul_new_idle");
    // Abort after one wait cycle, then a fresh full access.
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "abort_start");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "abort_drop");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "abort_idle");
    for (int i = 0; i < 3; i++) seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "abort_again_low");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "abort_again_done");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "abort_again_idle");
    // Disabled page never waits even when its select has wait states.
    seq(16'h0000, 1'b0, 1'b1, 5'h10, 8'h02, 1'b1, "dis_cfg_w");
    seq(16'h0000, 1'b0, 1'b1, 5'h00, 8'h00, 1'b1, "dis_cfg_map");
    seq(16'h0000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "dis_nowait");
    seq(16'h0000, 1'b0, 1'b1, 5'h00, 8'h80, 1'b1, "dis_restore");
    for (int i = 0; i < 2; i++) seq(16'h0000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "en_low");
    seq(16'h0000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "en_done");
    seq(16'h0000, 1'b0, 1'b1, 5'h10, 8'h00, 1'b1, "en_clear");

    // Reset asserted mid-wait with W=5.
    seq(16'h0000, 1'b0, 1'b1, 5'h11, 8'h05, 1'b1, "rstw_cfg");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "rstw_start");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, !WS, "rstw_wait1");
    #2;
    check("rstw_pre_rdy", bus.rdy, !WS);
    reset_n = 1'b0;
    #1;
    check("rstw_cs", bus.cs_n, 4'hF);
    check("rstw_rdy", bus.rdy, 1'b1);
    check("rstw_miss", bus.decode_miss, 1'b0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check("rstw_hold_cs", bus.cs_n, 4'hF);
    reset_n = 1'b1;
    @(posedge clock); #1;
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "rstw_after1");
    seq(16'hE000, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, "rstw_after2");
    seq(16'hE000, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, "rstw_after3");

    // Randomized traffic; address mostly held while an access is stretched.
    cur = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      if ((m_low == 0 && !m_done) || $urandom_range(0, 7) == 0)
        cur = 16'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ca = {1'b0, 4'($urandom_range(0, 9))};
        wd = {($urandom_range(0, 4) != 0), 3'($urandom), 4'($urandom_range(0, 5))};
      end else begin
        ca = {1'b1, 4'($urandom_range(0, 5))};
        wd = 8'($urandom);
      end
      step(cur, v, we, ca, wd, c, m, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
